mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the multicycle datapath's unified instruction/data memory. It accepts the address produced by the IorD address selector (PC, ALU result, stored result, or the exception-vector bytes 253/254/255). It performs a byte or word read/write against a 2^ADDR_W-byte big-endian store, holds the access for a programmable number of wait states, and returns data with a one-cycle acknowledge. The control unit is the initiator; this block is the responder at the other end of that address path.

## Interface
- ADDR_W, default 8: byte-address width of the store; depth is 2^ADDR_W bytes.
- WAIT_CYCLES, default 1: extra cycles between acceptance and acknowledge; legal range 0–15.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  access request; initiator holds it and all request fields stable until ack.
- we  in  1  1 = write, 0 = read.
- size  in  1  0 = byte, 1 = word (32-bit).
- addr  in  32  byte address from the IorD selector.
- wdata  in  32  write data; a byte write uses wdata[7:0].
- rdata  out  32  read data, valid only while ack=1; a byte read is zero-extended.
- ack  out  1  one-cycle completion pulse.
- err  out  1  valid with ack; 1 = access rejected, no state change.

## Operation
- FSM states:
  - IDLE: when req=1, latch we/size/addr/wdata, load the wait counter with WAIT_CYCLES, then go to WAIT. If WAIT_CYCLES=0, go directly to RESP.
  - WAIT: decrement the counter; on reaching 0, go to RESP.
  - RESP: ack=1 for exactly one cycle, then return to IDLE.
- Commit point: a write and the rdata/err capture both happen on the edge entering RESP.
- Error conditions:
  - Range error: addr ≥ 2^ADDR_W, or for a word access addr+3 ≥ 2^ADDR_W. The store is not written and rdata=0.
- Byte ordering is big-endian. For a word access at A:
  - byte A → [31:24]
  - byte A+1 → [23:16]
  - byte A+2 → [15:8]
  - byte A+3 → [7:0]
- A byte read at any address, including 253/254/255, returns {24'h0, mem[A]}.
- Request changes while in WAIT are ignored, because the fields were latched in IDLE.
- req still high in the IDLE cycle after ack is treated as a new request.
- Store contents are not reset. They are initialised only by simulation preload.

## Timing
- Reset values: ack=0, err=0, rdata=32'h0, state=IDLE, wait counter=0.
- Cycle 0 is the edge that samples req=1 in IDLE.
- ack is high during cycle WAIT_CYCLES+1 after cycle 0. Registered outputs give a minimum latency of 1 cycle.
- Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- Reset asserted before the RESP edge aborts the access: no write is committed, and no ack is issued.
- Reset asserted during RESP forces ack=0 immediately. The already committed write stays in the store.
- A read and a write to the same address never overlap, because only one access is outstanding.

## Configuration
- MEM_ALIGN_CHECK_EN:
  - Defined: a word access with addr[1:0]≠0 completes with err=1 and no write.
  - Undefined: addr[1:0] is forced to 0 for word accesses. Byte accesses are unaffected in both cases.

## Structure
- Shared package mem_pkg holds:
  - the size encoding constants (SIZE_BYTE, SIZE_WORD);
  - the FSM state enum (IDLE, WAIT, RESP);
  - the exception-vector byte addresses 253/254/255 as named constants, shared with the IorD selector.
- One sub-module, mem_byte_array: four byte-lane arrays with a lane-enable write port and a combinational read port. The FSM, wait counter and error checks stay in mem_responder.

## Test plan
- Reset: assert reset mid-simulation → ack=0, err=0, rdata=32'h0 immediately; the FSM is in IDLE.
- Word round-trip, WAIT_CYCLES=1:
  - Write 32'hDEADBEEF at 0x10 → ack in cycle 2, err=0.
  - Word read at 0x10 → rdata=32'hDEADBEEF.
  - Byte reads: 0x10 → 32'h000000DE; 0x13 → 32'h000000EF.
- Exception-vector bytes: byte write 8'hA5 at 253 → byte read 253 returns 32'h000000A5; word read at 252 has 8'hA5 in [23:16].
- Range: word read at 0xFE, and byte write at 0x100 → each acks with err=1; the store is unchanged, and rdata=0 on the read.
- Alignment:
  - Word write 32'h11223344 at 0x11.
  - With MEM_ALIGN_CHECK_EN: err=1, and 0x10 is unchanged.
  - Without it: a word read at 0x10 returns 32'h11223344.
- Abort: start a word write of 32'hCAFEF00D at 0x20 with WAIT_CYCLES=3, then pulse reset in WAIT → no ack; a later read of 0x20 returns the prior value.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the unified memory responder and the IorD address selector:
// size encoding, responder FSM states and the exception-vector byte addresses.
package mem_pkg;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    localparam int CNT_W = 4;

    // Exception-vector bytes sit at the very top of the 256-byte default store.
    localparam logic [31:0] EXC_VEC_0 = 32'd253;
    localparam logic [31:0] EXC_VEC_1 = 32'd254;
    localparam logic [31:0] EXC_VEC_2 = 32'd255;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Lane enable bit n selects byte offset n within a word (offset 0 is [31:24]).
    function automatic logic [3:0] lane_enable(input logic size, input logic [1:0] lane);
        if (size == SIZE_WORD) begin
            return 4'b1111;
        end
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Four byte-lane arrays forming a big-endian word store: lane n holds byte offset n
// and maps to data bits [31-8n -: 8]. Lane-enabled write port, combinational read.
module mem_byte_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        lane_en,
    input  logic [ADDR_W-3:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int WORDS = 1 << (ADDR_W - 2);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] bytes [WORDS];

        // Store contents are deliberately left unreset; only simulation preload sets them.
        always_ff @(posedge clk) begin
            if (we && lane_en[g]) begin
                bytes[idx] <= wdata[8*(3-g) +: 8];
            end
        end

        assign rdata[8*(3-g) +: 8] = bytes[idx];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: byte/word big-endian access with programmable wait states
// and a one-cycle ack. Optional macro MEM_ALIGN_CHECK_EN rejects unaligned word accesses.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err
);

    localparam logic [32:0] LIMIT = 33'd1 << ADDR_W;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               load;

    logic               lat_we, lat_size;
    logic [31:0]        lat_addr, lat_wdata;

    logic               cur_we, cur_size;
    logic [31:0]        cur_addr, cur_wdata;

    logic               range_err, align_err, acc_err;
    logic [ADDR_W-1:0]  eff_addr;
    logic               commit, mem_we;
    logic [3:0]         lane_en;
    logic [31:0]        arr_wdata, arr_rdata, read_val, rdata_nxt;
    logic [7:0]         byte_sel;

    // In IDLE a zero-wait access commits on the accepting edge, so use the live fields.
    assign cur_we    = (state == IDLE) ? we    : lat_we;
    assign cur_size  = (state == IDLE) ? size  : lat_size;
    assign cur_addr  = (state == IDLE) ? addr  : lat_addr;
    assign cur_wdata = (state == IDLE) ? wdata : lat_wdata;

    // Range is judged on the raw address, before any word-alignment forcing.
    assign range_err = ({1'b0, cur_addr} >= LIMIT) ||
                       ((cur_size == SIZE_WORD) && ({1'b0, cur_addr} + 33'd3 >= LIMIT));

`ifdef MEM_ALIGN_CHECK_EN
    assign align_err = (cur_size == SIZE_WORD) && (cur_addr[1:0] != 2'b00);
    assign eff_addr  = cur_addr[ADDR_W-1:0];
`else
    assign align_err = 1'b0;
    assign eff_addr  = (cur_size == SIZE_WORD) ? {cur_addr[ADDR_W-1:2], 2'b00}
                                               : cur_addr[ADDR_W-1:0];
`endif

    assign acc_err   = range_err || align_err;
    assign commit    = (state_nxt == RESP) && (state != RESP);
    assign mem_we    = commit && cur_we && !acc_err;
    assign lane_en   = lane_enable(cur_size, eff_addr[1:0]);
    assign arr_wdata = (cur_size == SIZE_WORD) ? cur_wdata : {4{cur_wdata[7:0]}};

    mem_byte_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .we      (mem_we),
        .lane_en (lane_en),
        .idx     (eff_addr[ADDR_W-1:2]),
        .wdata   (arr_wdata),
        .rdata   (arr_rdata)
    );

    always_comb begin
        byte_sel = 8'h00;
        case (eff_addr[1:0])
            2'd0:    byte_sel = arr_rdata[31:24];
            2'd1:    byte_sel = arr_rdata[23:16];
            2'd2:    byte_sel = arr_rdata[15:8];
            default: byte_sel = arr_rdata[7:0];
        endcase
    end

    assign read_val  = (cur_size == SIZE_WORD) ? arr_rdata : {24'h0, byte_sel};
    assign rdata_nxt = (cur_we || acc_err) ? 32'h0 : read_val;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    load = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                // The counter reaching zero on this edge is the edge that enters RESP.
                if (cnt <= CNT_W'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_size  <= SIZE_BYTE;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            ack       <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'h0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load) begin
                lat_we    <= we;
                lat_size  <= size;
                lat_addr  <= addr;
                lat_wdata <= wdata;
            end
            ack   <= commit;
            err   <= commit && acc_err;
            rdata <= commit ? rdata_nxt : 32'h0;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with one wait state, one with three
// for the abort scenario. Expected responses are queued at issue and checked on ack.
module tb_mem_responder;
    import mem_pkg::*;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        logic        chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset1, reset3, req1, req3, we, size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata1, rdata3;
    logic        ack1, ack3, err1, err3;

    exp_t q1[$];
    exp_t q3[$];
    int   tests = 0;
    int   fails = 0;
    logic [31:0] exp10;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset1), .req(req1), .we(we), .size(size),
        .addr(addr), .wdata(wdata), .rdata(rdata1), .ack(ack1), .err(err1)
    );

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset3), .req(req3), .we(we), .size(size),
        .addr(addr), .wdata(wdata), .rdata(rdata3), .ack(ack3), .err(err3)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Issue one access from a negedge, wait for ack and check the ack latency.
    task automatic applyStimulus(input bit use3, input logic we_i, input logic size_i,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic experr, input logic [31:0] exprd,
                                 input logic chk, input int lat);
        exp_t e;
        int   k;
        e.err = experr; e.rdata = exprd; e.chk = chk;
        if (use3) q3.push_back(e); else q1.push_back(e);
        we = we_i; size = size_i; addr = a; wdata = wd;
        if (use3) req3 = 1'b1; else req1 = 1'b1;
        @(posedge clk);
        k = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            k++;
            if ((use3 ? ack3 : ack1) === 1'b1) break;
        end
        req1 = 1'b0; req3 = 1'b0;
        checkOutput($sformatf("ack_latency_%h", a), k, lat);
    endtask

    task automatic monitorPop(input bit use3, input logic a_err, input logic [31:0] a_rd);
        exp_t e;
        tests++;
        if ((use3 ? q3.size() : q1.size()) == 0) begin
            fails++;
            $display("[TB] FAIL unexpected_ack dut%0d: err=%b rdata=%h, expected no ack",
                     use3 ? 3 : 1, a_err, a_rd);
        end else begin
            e = use3 ? q3.pop_front() : q1.pop_front();
            if (a_err !== e.err || (e.chk && a_rd !== e.rdata)) begin
                fails++;
                $display("[TB] FAIL response dut%0d: err=%b rdata=%h, expected err=%b rdata=%h",
                         use3 ? 3 : 1, a_err, a_rd, e.err, e.rdata);
            end
        end
    endtask

    initial begin
        reset1 = 1'b1; reset3 = 1'b1; req1 = 1'b0; req3 = 1'b0;
        we = 1'b0; size = SIZE_BYTE; addr = 32'h0; wdata = 32'h0;

        fork
            forever begin
                @(negedge clk);
                if (ack1 === 1'b1) monitorPop(1'b0, err1, rdata1);
                if (ack3 === 1'b1) monitorPop(1'b1, err3, rdata3);
            end
        join_none

        repeat (2) @(negedge clk);
        checkOutput("reset_ack", {31'h0, ack1}, 32'h0);
        checkOutput("reset_err", {31'h0, err1}, 32'h0);
        checkOutput("reset_rdata", rdata1, 32'h0);
        checkOutput("reset_state", 32'(dut1.state), 32'(IDLE));
        reset1 = 1'b0; reset3 = 1'b0;
        @(negedge clk);

        $display("[TB] word round-trip");
        applyStimulus(0, 1, SIZE_WORD, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0, 2);
        @(negedge clk);
        applyStimulus(0, 0, SIZE_WORD, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1, 2);
        @(negedge clk);
        applyStimulus(0, 0, SIZE_BYTE, 32'h10, 32'h0, 0, 32'h000000DE, 1, 2);
        @(negedge clk);
        applyStimulus(0, 0, SIZE_BYTE, 32'h11, 32'h0, 0, 32'h000000AD, 1, 2);
        @(negedge clk);
        applyStimulus(0, 0, SIZE_BYTE, 32'h13, 32'h0, 0, 32'h000000EF, 1, 2);
        @(negedge clk);

        $display("[TB] exception-vector bytes");
        applyStimulus(0, 1, SIZE_WORD, 32'd252, 32'h00000000, 0, 32'h0, 0, 2);
        @(negedge clk);
        applyStimulus(0, 1, SIZE_BYTE, EXC_VEC_0, 32'hFFFFFFA5, 0, 32'h0, 0, 2);
        @(negedge clk);
        applyStimulus(0, 0, SIZE_BYTE, EXC_VEC_0, 32'h0, 0, 32'h000000A5, 1, 2);
        @(negedge clk);
        applyStimulus(0, 0, SIZE_BYTE, EXC_VEC_2, 32'h0, 0, 32'h00000000, 1, 2);
        @(negedge clk);
        applyStimulus(0, 0, SIZE_WORD, 32'd252, 32'h0, 0, 32'h00A50000, 1, 2);
        @(negedge clk);

        $display("[TB] range errors");
        applyStimulus(0, 1, SIZE_WORD, 32'h00, 32'h01020304, 0, 32'h0, 0, 2);
        @(negedge clk);
        applyStimulus(0, 1, SIZE_BYTE, 32'h100, 32'h000000FF, 1, 32'h0, 0, 2);
        @(negedge clk);
        applyStimulus(0, 0, SIZE_BYTE, 32'h00, 32'h0, 0, 32'h00000001, 1, 2);
        @(negedge clk);
        applyStimulus(0, 0, SIZE_WORD, 32'hFE, 32'h0, 1, 32'h0, 1, 2);
        @(negedge clk);
        applyStimulus(0, 0, SIZE_BYTE, 32'h1010, 32'h0, 1, 32'h0, 1, 2);
        @(negedge clk);

        $display("[TB] reset during RESP");
        applyStimulus(0, 0, SIZE_WORD, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1, 2);
        #1 reset1 = 1'b1;
        #1;
        checkOutput("midreset_ack", {31'h0, ack1}, 32'h0);
        checkOutput("midreset_err", {31'h0, err1}, 32'h0);
        checkOutput("midreset_rdata", rdata1, 32'h0);
        checkOutput("midreset_state", 32'(dut1.state), 32'(IDLE));
        @(negedge clk);
        reset1 = 1'b0;
        @(negedge clk);

        $display("[TB] alignment");
`ifdef MEM_ALIGN_CHECK_EN
        applyStimulus(0, 1, SIZE_WORD, 32'h11, 32'h11223344, 1, 32'h0, 0, 2);
        exp10 = 32'hDEADBEEF;
`else
        applyStimulus(0, 1, SIZE_WORD, 32'h11, 32'h11223344, 0, 32'h0, 0, 2);
        exp10 = 32'h11223344;
`endif
        @(negedge clk);
        applyStimulus(0, 0, SIZE_WORD, 32'h10, 32'h0, 0, exp10, 1, 2);
        @(negedge clk);

        $display("[TB] abort in WAIT");
        applyStimulus(1, 1, SIZE_WORD, 32'h20, 32'h55667788, 0, 32'h0, 0, 4);
        @(negedge clk);
        we = 1'b1; size = SIZE_WORD; addr = 32'h20; wdata = 32'hCAFEF00D; req3 = 1'b1;
        @(posedge clk);
        repeat (2) @(negedge clk);
        checkOutput("abort_in_wait", 32'(dut3.state), 32'(WAIT));
        reset3 = 1'b1; req3 = 1'b0;
        @(negedge clk);
        reset3 = 1'b0;
        repeat (8) @(negedge clk);
        applyStimulus(1, 0, SIZE_WORD, 32'h20, 32'h0, 0, 32'h55667788, 1, 4);
        repeat (3) @(negedge clk);

        checkOutput("pending_q1", q1.size(), 32'h0);
        checkOutput("pending_q3", q3.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
